// File: rtl/expr_seq_pkg.sv
// expr_seq_pkg
// Shared types and constants for the expression vector sequencer:
//   - sequencer state enum
//   - LFSR tap mask, MISR polynomial and signature seed value
//   - bit offsets/widths of the twelve operand fields on the 60-bit bus
//   - one-step Galois LFSR helper used by the top level
package expr_seq_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StDrive   = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } seqState_e;

   localparam int OPND_W = 60;
   localparam int RES_W  = 90;

   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SIG_INIT  = 32'hFFFF_FFFF;

   // Operand field layout, a0 in the low bits and b5 at the top
   localparam int A0_OFF = 0;   localparam int A0_W = 4;
   localparam int A1_OFF = 4;   localparam int A1_W = 5;
   localparam int A2_OFF = 9;   localparam int A2_W = 6;
   localparam int A3_OFF = 15;  localparam int A3_W = 4;
   localparam int A4_OFF = 19;  localparam int A4_W = 5;
   localparam int A5_OFF = 24;  localparam int A5_W = 6;
   localparam int B0_OFF = 30;  localparam int B0_W = 4;
   localparam int B1_OFF = 34;  localparam int B1_W = 5;
   localparam int B2_OFF = 39;  localparam int B2_W = 6;
   localparam int B3_OFF = 45;  localparam int B3_W = 4;
   localparam int B4_OFF = 49;  localparam int B4_W = 5;
   localparam int B5_OFF = 54;  localparam int B5_W = 6;

   // Right-shifting Galois step: the bit shifted out decides whether the
   // tap mask is folded back in at the top.
   function automatic logic [63:0] lfsrStep(input logic [63:0] l);
      logic [63:0] shifted;
      shifted = l >> 1;
      return l[0] ? (shifted ^ LFSR_TAPS) : shifted;
   endfunction

endpackage

// File: rtl/expr_misr.sv
// expr_misr
// 32-bit multiple-input signature register that compresses each 90-bit
// expression result into a running signature.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (signature -> SIG_INIT)
//   init_i  in   reload SIG_INIT at the next edge (wins over en_i)
//   en_i    in   absorb res_i at the next edge
//   res_i   in   90-bit result bus
//   sig_o   out  current signature
module expr_misr
   import expr_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init_i,
   input  logic             en_i,
   input  logic [RES_W-1:0] res_i,
   output logic [31:0]      sig_o
);

   logic [31:0] fold;
   logic [31:0] sig_d;
   logic [31:0] sig_q;

   // The 90-bit result is folded to 32 bits by XOR of its three slices, then
   // shifted into the CRC-32 style register.
   always_comb begin
      fold  = res_i[31:0] ^ res_i[63:32] ^ {6'b0, res_i[89:64]};
      sig_d = sig_q;
      if (init_i) begin
         sig_d = SIG_INIT;
      end else if (en_i) begin
         sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;
      end
   end

   // Signature register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= SIG_INIT;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer
// Drives pseudo-random operand vectors into a combinational expression block,
// holds each for SETTLE+1 cycles, samples the result on the last of them and
// compresses all results into one MISR signature.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        begin a run (only in IDLE/DONE); samples seed and num_vec
//   abort        return to IDLE at the next edge; wins over start
//   seed         32-bit LFSR seed
//   num_vec      vectors per run
//   opnd_o       60-bit packed operands, lfsr[59:0]
//   res_i        90-bit result from the expression block
//   busy         high in DRIVE and CAPTURE
//   done         high in DONE
//   vec_count    vectors captured in the current or last run
//   signature    MISR value
module expr_vector_sequencer
   import expr_seq_pkg::*;
#(
   parameter int SETTLE = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [31:0]       seed,
   input  logic [CNT_W-1:0]  num_vec,
   output logic [OPND_W-1:0] opnd_o,
   input  logic [RES_W-1:0]  res_i,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  vec_count,
   output logic [31:0]       signature
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   seqState_e        state_q;
   logic [63:0]      lfsr_q;
   logic [3:0]       settle_q;
   logic [CNT_W-1:0] vecCount_q;
   logic [CNT_W-1:0] numVec_q;
   logic [CNT_W-1:0] vecNext;
   logic             busy_q;
   logic             done_q;
   logic             startOk;
   logic             capture;

   assign startOk = start && !abort && (state_q == StIdle || state_q == StDone);
   assign capture = (state_q == StCapture);
   assign vecNext = vecCount_q + CNT_ONE;

   // Sequencer FSM with counters and LFSR. A capture that coincides with
   // abort still completes, so the partial signature, count and LFSR left
   // behind by an abort include the vector sampled on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         lfsr_q     <= '0;
         settle_q   <= '0;
         vecCount_q <= '0;
         numVec_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (capture) begin
            vecCount_q <= vecNext;
            lfsr_q     <= lfsrStep(lfsr_q);
         end
         if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (start) begin
                     lfsr_q     <= {seed, ~seed};
                     vecCount_q <= '0;
                     settle_q   <= '0;
                     numVec_q   <= num_vec;
                     if (num_vec == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= StDrive;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                     end
                  end
               end
               StDrive: begin
                  settle_q <= settle_q + 4'd1;
                  if (settle_q == SETTLE_LAST) begin
                     state_q <= StCapture;
                  end
               end
               StCapture: begin
                  settle_q <= '0;
                  if (vecNext == numVec_q) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StDrive;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   expr_misr uMisr (
      .clk    (clk),
      .rst_n  (rst_n),
      .init_i (startOk),
      .en_i   (capture),
      .res_i  (res_i),
      .sig_o  (signature)
   );

   assign opnd_o    = lfsr_q[OPND_W-1:0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign vec_count = vecCount_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer
// Two sequencer instances (SETTLE=1 and SETTLE=2) share seed/num_vec and each
// drive their own copy of a small combinational "expression" function. Every
// cycle of each run is compared with a timeline derived from the run length
// arithmetic plus a vector-by-vector LFSR/MISR reference.
module tb_expr_vector_sequencer;

   localparam int CNT_W = 16;
   localparam int PA    = 2;
   localparam int PB    = 3;

   logic             clk = 1'b0;
   logic             rstN;
   logic             startA, startB, abortA, abortB;
   logic [31:0]      seed;
   logic [CNT_W-1:0] numVec;
   logic             zeroRes;
   logic [59:0]      opndA, opndB;
   logic [89:0]      resA, resB;
   logic             busyA, busyB, doneA, doneB;
   logic [CNT_W-1:0] vecA, vecB;
   logic [31:0]      sigA, sigB;

   int checks = 0;
   int errors = 0;

   logic [63:0] expLfsr[$];
   logic [31:0] expSig[$];

   typedef struct {
      logic [31:0] seed;
      int          numVec;
      bit          zeroRes;
      bit          doAbort;
      bit          spurious;
      int          expVec;
      bit          expDone;
      bit          sigKnown;
      logic [31:0] expSig;
      bit          opndKnown;
      logic [59:0] expOpnd;
   } vecRow_t;

   always #5 clk = ~clk;

   // Stand-in for the expression block: any deterministic 60->90 bit function
   function automatic logic [89:0] respond(input logic [59:0] op);
      logic [29:0] lo;
      logic [29:0] hi;
      lo = op[29:0];
      hi = op[59:30];
      return {hi ^ {lo[28:0], lo[29]}, op ^ {lo, hi}};
   endfunction

   assign resA = zeroRes ? 90'd0 : respond(opndA);
   assign resB = zeroRes ? 90'd0 : respond(opndB);

   expr_vector_sequencer #(.SETTLE(1), .CNT_W(CNT_W)) dutA (
      .clk(clk), .rst_n(rstN), .start(startA), .abort(abortA), .seed(seed),
      .num_vec(numVec), .opnd_o(opndA), .res_i(resA), .busy(busyA),
      .done(doneA), .vec_count(vecA), .signature(sigA)
   );

   expr_vector_sequencer #(.SETTLE(2), .CNT_W(CNT_W)) dutB (
      .clk(clk), .rst_n(rstN), .start(startB), .abort(abortB), .seed(seed),
      .num_vec(numVec), .opnd_o(opndB), .res_i(resB), .busy(busyB),
      .done(doneB), .vec_count(vecB), .signature(sigB)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Reference: list of LFSR states and signatures after 0..n vectors
   task automatic buildModel(input logic [31:0] sd, input int n, input bit zero);
      logic [63:0] l;
      logic [31:0] s;
      logic [89:0] r;
      logic [31:0] f;
      expLfsr.delete();
      expSig.delete();
      l = {sd, ~sd};
      s = 32'hFFFF_FFFF;
      expLfsr.push_back(l);
      expSig.push_back(s);
      for (int v = 0; v < n; v++) begin
         r = zero ? 90'd0 : respond(l[59:0]);
         f = r[31:0] ^ r[63:32] ^ {6'd0, r[89:64]};
         s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'd0) ^ f;
         l = (l >> 1) ^ (l[0] ? 64'hD800_0000_0000_0000 : 64'd0);
         expLfsr.push_back(l);
         expSig.push_back(s);
      end
   endtask

   // Expected outputs k edges after the start edge, for hold period p
   task automatic checkDut(input string tag, input int p, input int k, input int n,
                           input int abortEdge, input logic [59:0] op, input logic b,
                           input logic d, input logic [CNT_W-1:0] vc,
                           input logic [31:0] sg);
      int idx;
      bit eb;
      bit ed;
      if (abortEdge >= 0 && k >= abortEdge) begin
         idx = abortEdge / p; eb = 1'b0; ed = 1'b0;
      end else if (k < n * p) begin
         idx = k / p; eb = 1'b1; ed = 1'b0;
      end else begin
         idx = n; eb = 1'b0; ed = 1'b1;
      end
      checkOutput({tag, "_opnd"}, {4'd0, op}, {4'd0, expLfsr[idx][59:0]});
      checkOutput({tag, "_busy"}, {63'd0, b}, {63'd0, eb});
      checkOutput({tag, "_done"}, {63'd0, d}, {63'd0, ed});
      checkOutput({tag, "_vec_count"}, {48'd0, vc}, 64'(idx));
      checkOutput({tag, "_signature"}, {32'd0, sg}, {32'd0, expSig[idx]});
   endtask

   task automatic checkReset();
      checkOutput("rst_opndA", {4'd0, opndA}, 64'd0);
      checkOutput("rst_busyA", {63'd0, busyA}, 64'd0);
      checkOutput("rst_doneA", {63'd0, doneA}, 64'd0);
      checkOutput("rst_vecA", {48'd0, vecA}, 64'd0);
      checkOutput("rst_sigA", {32'd0, sigA}, 64'h0000_0000_FFFF_FFFF);
      checkOutput("rst_opndB", {4'd0, opndB}, 64'd0);
      checkOutput("rst_busyB", {63'd0, busyB}, 64'd0);
      checkOutput("rst_doneB", {63'd0, doneB}, 64'd0);
      checkOutput("rst_vecB", {48'd0, vecB}, 64'd0);
      checkOutput("rst_sigB", {32'd0, sigB}, 64'h0000_0000_FFFF_FFFF);
   endtask

   // One complete run on both instances, checked every cycle. Optional abort
   // (with a simultaneous start) lands in the 2nd CAPTURE of each instance;
   // optional spurious start with another seed lands on edge 2 mid-run.
   task automatic applyStimulus(input logic [31:0] sd, input int n, input bit zero,
                                input bit doAbort, input bit spurious);
      int aeA;
      int aeB;
      int lastEdge;
      aeA = doAbort ? 2 * PA : -1;
      aeB = doAbort ? 2 * PB : -1;
      lastEdge = (doAbort ? 2 * PB : n * PB) + 2;
      buildModel(sd, n, zero);
      @(negedge clk);
      seed = sd; numVec = CNT_W'(n); zeroRes = zero;
      startA = 1'b1; startB = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= lastEdge; k++) begin
         @(negedge clk);
         startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
         seed = sd ^ 32'hA5A5_5A5A;
         numVec = CNT_W'(n + 7);
         checkDut("A", PA, k, n, aeA, opndA, busyA, doneA, vecA, sigA);
         checkDut("B", PB, k, n, aeB, opndB, busyB, doneB, vecB, sigB);
         if (k + 1 == aeA) begin abortA = 1'b1; startA = 1'b1; end
         if (k + 1 == aeB) begin abortB = 1'b1; startB = 1'b1; end
         if (spurious && k + 1 == 2) begin startA = 1'b1; startB = 1'b1; end
         @(posedge clk);
      end
   endtask

   initial begin
      vecRow_t rows[$];
      vecRow_t r;
      rstN = 1'b0; startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
      seed = '0; numVec = '0; zeroRes = 1'b0;

      rows.push_back('{32'h0000_0000, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 60'h0000000_FFFFFFFF});
      rows.push_back('{32'h0000_0000, 1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'hFB3E_E249, 1'b1, 60'h8000000_7FFFFFFF});
      rows.push_back('{32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 32'h0, 1'b0, 60'h0});
      rows.push_back('{32'hCAFE_F00D, 5, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 32'h0, 1'b0, 60'h0});
      rows.push_back('{32'h0BAD_BEEF, 4, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 32'h0, 1'b0, 60'h0});
      for (int i = 0; i < 8; i++) begin
         r.seed     = $urandom;
         r.numVec   = int'($urandom_range(1, 6));
         r.zeroRes  = 1'b0;
         r.doAbort  = (r.numVec >= 3) && ($urandom_range(0, 1) == 1);
         r.spurious = !r.doAbort && (r.numVec >= 2) && ($urandom_range(0, 1) == 1);
         r.expVec   = r.doAbort ? 2 : r.numVec;
         r.expDone  = !r.doAbort;
         r.sigKnown = 1'b0; r.expSig = '0; r.opndKnown = 1'b0; r.expOpnd = '0;
         rows.push_back(r);
      end

      #12;
      checkReset();
      @(negedge clk);
      rstN = 1'b1;

      foreach (rows[i]) begin
         applyStimulus(rows[i].seed, rows[i].numVec, rows[i].zeroRes,
                       rows[i].doAbort, rows[i].spurious);
         @(negedge clk);
         checkOutput($sformatf("row%0d_vecA", i), {48'd0, vecA}, 64'(rows[i].expVec));
         checkOutput($sformatf("row%0d_vecB", i), {48'd0, vecB}, 64'(rows[i].expVec));
         checkOutput($sformatf("row%0d_doneA", i), {63'd0, doneA}, {63'd0, rows[i].expDone});
         checkOutput($sformatf("row%0d_doneB", i), {63'd0, doneB}, {63'd0, rows[i].expDone});
         if (rows[i].sigKnown) begin
            checkOutput($sformatf("row%0d_sigA", i), {32'd0, sigA}, {32'd0, rows[i].expSig});
            checkOutput($sformatf("row%0d_sigB", i), {32'd0, sigB}, {32'd0, rows[i].expSig});
         end
         if (rows[i].opndKnown) begin
            checkOutput($sformatf("row%0d_opndA", i), {4'd0, opndA}, {4'd0, rows[i].expOpnd});
            checkOutput($sformatf("row%0d_opndB", i), {4'd0, opndB}, {4'd0, rows[i].expOpnd});
         end
      end

      // Asynchronous reset in the middle of DRIVE, checked before any edge
      @(negedge clk);
      seed = 32'h1111_2222; numVec = CNT_W'(5); zeroRes = 1'b0;
      startA = 1'b1; startB = 1'b1;
      @(posedge clk);
      @(negedge clk);
      startA = 1'b0; startB = 1'b0;
      checkOutput("pre_rst_busyA", {63'd0, busyA}, 64'd1);
      #2 rstN = 1'b0;
      #1 checkReset();
      @(negedge clk);
      rstN = 1'b1;

      // First start after reset release is honoured normally
      applyStimulus(32'h7654_3210, 2, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
